// File: rtl/universal_shift_register_p.sv
// Parametrised universal shift/rotate/load register with an auto-repeat sequencer that
// applies one latched operation count times under a start/busy/done handshake.
module universal_shift_register_p #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sin_msb,
  input  logic               sin_lsb,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   count,
  output logic [WIDTH-1:0]   data_out,
  output logic               sout_msb,
  output logic               sout_lsb,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] ModeShr  = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeLoad = 3'b011;
  localparam logic [2:0] ModeRor  = 3'b100;
  localparam logic [2:0] ModeRol  = 3'b101;
  localparam logic [2:0] ModeAsr  = 3'b110;

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   data_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [WIDTH-1:0]   idle_next;
  logic [WIDTH-1:0]   run_next;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0]   r,
    input logic [2:0]         op,
    input logic [SHAMT_W-1:0] amt,
    input logic               msb_in,
    input logic               lsb_in,
    input logic [WIDTH-1:0]   load
  );
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] dbl_sh;
    int unsigned        rot;
    dbl    = {r, r};
    rot    = 32'(amt) % WIDTH;
    dbl_sh = '0;
    apply_op = r;
    case (op)
      ModeShr:  apply_op = {msb_in, r[WIDTH-1:1]};
      ModeShl:  apply_op = {r[WIDTH-2:0], lsb_in};
      ModeLoad: apply_op = load;
      // Rotates take the matching half of the doubled word after a plain shift.
      ModeRor: begin
        dbl_sh   = dbl >> rot;
        apply_op = dbl_sh[WIDTH-1:0];
      end
      ModeRol: begin
        dbl_sh   = dbl << rot;
        apply_op = dbl_sh[2*WIDTH-1:WIDTH];
      end
      ModeAsr:  apply_op = $signed(r) >>> amt;
      default:  apply_op = r;
    endcase
  endfunction

  always_comb begin
    idle_next = apply_op(data_q, mode, shamt, sin_msb, sin_lsb, data_in);
    run_next  = apply_op(data_q, mode_q, shamt_q, sin_msb, sin_lsb, data_in);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (count != '0) begin
              mode_q  <= mode;
              shamt_q <= shamt;
              cnt_q   <= count;
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end else if (enable) begin
            data_q <= idle_next;
          end
        end
        StRun: begin
          data_q <= run_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out = data_q;
  assign sout_msb = data_q[WIDTH-1];
  assign sout_lsb = data_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_universal_shift_register_p.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_universal_shift_register_p;

  logic       clock, reset;
  logic       enable, sin_msb, sin_lsb, start;
  logic [2:0] mode, shamt;
  logic [7:0] data_in, count, data_out;
  logic       sout_msb, sout_lsb, busy, done;

  logic       en5, sin_msb5, sin_lsb5, start5;
  logic [2:0] mode5, shamt5;
  logic [4:0] din5, dout5;
  logic [7:0] count5;
  logic       smsb5, slsb5, busy5, done5;

  universal_shift_register_p #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .shamt(shamt),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .data_in(data_in), .start(start), .count(count),
    .data_out(data_out), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  universal_shift_register_p #(.WIDTH(5)) u5 (
    .clock(clock), .reset(reset), .enable(en5), .mode(mode5), .shamt(shamt5),
    .sin_msb(sin_msb5), .sin_lsb(sin_lsb5), .data_in(din5), .start(start5), .count(count5),
    .data_out(dout5), .sout_msb(smsb5), .sout_lsb(slsb5), .busy(busy5), .done(done5)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         w5;
    logic [7:0] d;
    logic       b;
    logic       dn;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clock) begin
    logic [7:0] ad;
    logic       ab, adn, amsb, alsb, emsb;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
      end else begin
        ad   = e.w5 ? {3'b000, dout5} : data_out;
        ab   = e.w5 ? busy5 : busy;
        adn  = e.w5 ? done5 : done;
        amsb = e.w5 ? smsb5 : sout_msb;
        alsb = e.w5 ? slsb5 : sout_lsb;
        emsb = e.w5 ? e.d[4] : e.d[7];
        if (ad !== e.d || ab !== e.b || adn !== e.dn || amsb !== emsb || alsb !== e.d[0]) begin
          errors++;
          $display("FAIL %s @%0d: got data=%h busy=%b done=%b smsb=%b slsb=%b, want data=%h busy=%b done=%b smsb=%b slsb=%b",
                   e.name, cyc, ad, ab, adn, amsb, alsb, e.d, e.b, e.dn, emsb, e.d[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int dc, input string nm, input bit w5, input logic [7:0] d,
                      input logic b, input logic dn);
    exp_t x;
    x.cyc = cyc + dc; x.name = nm; x.w5 = w5; x.d = d; x.b = b; x.dn = dn;
    q.push_back(x);
  endtask

  task automatic op8(input logic [2:0] m, input logic [2:0] s, input logic [7:0] ex,
                     input string nm);
    enable = 1'b1; mode = m; shamt = s;
    push(1, nm, 1'b0, ex, 1'b0, 1'b0);
    step();
    enable = 1'b0;
  endtask

  task automatic load8(input logic [7:0] v);
    data_in = v;
    op8(3'b011, 3'd0, v, "load");
  endtask

  task automatic op5(input logic [2:0] m, input logic [2:0] s, input logic [4:0] ex,
                     input string nm);
    en5 = 1'b1; mode5 = m; shamt5 = s;
    push(1, nm, 1'b1, {3'b000, ex}, 1'b0, 1'b0);
    step();
    en5 = 1'b0;
  endtask

  bit         sbits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] sexp[8]  = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};

  initial begin
    reset = 1'b1; enable = 0; mode = 0; shamt = 0; sin_msb = 0; sin_lsb = 0;
    data_in = 0; start = 0; count = 0;
    en5 = 0; mode5 = 0; shamt5 = 0; sin_msb5 = 0; sin_lsb5 = 0; din5 = 0; start5 = 0;
    count5 = 0;
    step(); step();
    push(0, "reset", 1'b0, 8'h00, 1'b0, 1'b0);
    push(0, "reset5", 1'b1, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // IDLE single operations on 1001_0110
    load8(8'h96); sin_msb = 1'b1; op8(3'b001, 3'd0, 8'hCB, "shr_sin1");
    load8(8'h96); sin_lsb = 1'b0; op8(3'b010, 3'd0, 8'h2C, "shl_sin0");
    load8(8'h96); op8(3'b100, 3'd3, 8'hD2, "ror3");
    load8(8'h96); op8(3'b110, 3'd2, 8'hE5, "asr2");
    load8(8'h96); op8(3'b111, 3'd5, 8'h96, "reserved");
    op8(3'b000, 3'd0, 8'h96, "hold");
    op8(3'b100, 3'd0, 8'h96, "ror0");
    op8(3'b101, 3'd0, 8'h96, "rol0");
    op8(3'b110, 3'd7, 8'hFF, "asr7");
    load8(8'h96); mode = 3'b001; enable = 1'b0;
    push(1, "enable_low", 1'b0, 8'h96, 1'b0, 1'b0); step();

    // Rotate-left sequence, with enable asserted alongside start
    load8(8'h81);
    start = 1'b1; enable = 1'b1; mode = 3'b101; shamt = 3'd1; count = 8'd4;
    push(1, "seq_t0", 1'b0, 8'h81, 1'b1, 1'b0); step();
    start = 1'b0; mode = 3'b011; data_in = 8'hFF; shamt = 3'd7; count = 8'd9;
    push(1, "seq_t1", 1'b0, 8'h03, 1'b1, 1'b0); step();
    push(1, "seq_t2", 1'b0, 8'h06, 1'b1, 1'b0); step();
    push(1, "seq_t3", 1'b0, 8'h0C, 1'b1, 1'b0); step();
    push(1, "seq_done", 1'b0, 8'h18, 1'b0, 1'b1); step();
    enable = 1'b0;
    push(1, "seq_after", 1'b0, 8'h18, 1'b0, 1'b0); step();

    // count=0 start
    start = 1'b1; count = 8'd0; mode = 3'b001;
    push(1, "cnt0_done", 1'b0, 8'h18, 1'b0, 1'b1); step();
    start = 1'b0;
    push(1, "cnt0_after", 1'b0, 8'h18, 1'b0, 1'b0); step();

    // Serial stream through shift right
    load8(8'h00);
    start = 1'b1; mode = 3'b001; count = 8'd8;
    push(1, "ser_t0", 1'b0, 8'h00, 1'b1, 1'b0); step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin_msb = sbits[i];
      push(1, "serial", 1'b0, sexp[i], (i != 7), (i == 7)); step();
    end
    push(1, "ser_after", 1'b0, 8'h4D, 1'b0, 1'b0); step();

    // Reset mid-RUN abandons the sequence
    load8(8'hA5); sin_msb = 1'b0;
    start = 1'b1; mode = 3'b001; count = 8'd5;
    push(1, "rst_t0", 1'b0, 8'hA5, 1'b1, 1'b0); step();
    start = 1'b0;
    push(1, "rst_t1", 1'b0, 8'h52, 1'b1, 1'b0); step();
    reset = 1'b1;
    push(1, "rst_mid", 1'b0, 8'h00, 1'b0, 1'b0); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1, "rst_nodone", 1'b0, 8'h00, 1'b0, 1'b0); step();
    end

    // WIDTH=5: shamt beyond width
    din5 = 5'b10110; op5(3'b011, 3'd0, 5'b10110, "w5_load");
    op5(3'b100, 3'd7, 5'b10101, "w5_ror7");
    op5(3'b011, 3'd0, 5'b10110, "w5_reload");
    op5(3'b101, 3'd7, 5'b11010, "w5_rol7");
    op5(3'b011, 3'd0, 5'b10110, "w5_reload2");
    op5(3'b110, 3'd6, 5'b11111, "w5_asr6");

    repeat (3) step();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
